// File: rtl/jump_button_conditioner_pkg.sv
// Shared constants for the jump button conditioner: FSM encoding, board
// defaults and a small edge helper.
package jump_button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HOLD     = 2'b01,
        WAIT_REL = 2'b10,
        RSVD     = 2'b11
    } jbc_state_e;

    // 50 MHz board: 1 ms debounce, ~82 us jump pulse
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd50000;
    localparam int unsigned DEF_HOLD_CYCLES     = 32'd4096;
    localparam int unsigned DEF_CNT_W           = 32'd16;

    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/jump_button_conditioner_if.sv
// Button-side and processor-side signals of the jump button conditioner.
interface jump_button_conditioner_if;

    logic       btn_raw;
    logic       io_jump;
    logic       btn_level;
    logic [7:0] press_count;
    logic       busy;

    modport master (
        output btn_raw,
        input  io_jump,
        input  btn_level,
        input  press_count,
        input  busy
    );

    modport slave (
        input  btn_raw,
        output io_jump,
        output btn_level,
        output press_count,
        output busy
    );

endinterface

// File: rtl/jump_button_conditioner_button_debounce.sv
// Two-flop synchroniser followed by a consecutive-mismatch debounce counter;
// the debounced level only flips after DEBOUNCE_CYCLES disagreeing cycles.
module button_debounce
    import jump_button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic btn_level_o
);

    localparam logic [CNT_W-1:0] DCNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DCNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DCNT_ONE  = CNT_W'(32'd1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;

    // Any agreeing sample restarts the count, so short glitches never land
    always_comb begin
        level_d = level_q;
        dcnt_d  = DCNT_ZERO;
        if (sync2_q == level_q) begin
            dcnt_d = DCNT_ZERO;
        end else if (dcnt_q == DCNT_MAX) begin
            level_d = sync2_q;
            dcnt_d  = DCNT_ZERO;
        end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
        end
    end

    // Synchroniser and debounce state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            dcnt_q  <= DCNT_ZERO;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign btn_level_o = level_q;

endmodule

// File: rtl/jump_button_conditioner.sv
// Turns the raw jump button into a fixed-length io_jump pulse per press,
// blocks auto-repeat while held and counts accepted presses.
module jump_button_conditioner
    import jump_button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    jump_button_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] HCNT_MAX  = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] HCNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] HCNT_ONE  = CNT_W'(32'd1);

    logic             btn_level_s;
    logic             rise_s;
    logic             lvl_d_q;
    jbc_state_e       state_q;
    jbc_state_e       state_d;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] hcnt_d;
    logic             io_jump_q;
    logic             io_jump_d;
    logic             busy_q;
    logic             busy_d;
    logic [7:0]       press_count_q;
    logic [7:0]       press_count_d;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .btn_raw_i   (bus.btn_raw),
        .btn_level_o (btn_level_s)
    );

    assign rise_s = rise_edge(btn_level_s, lvl_d_q);

    // Next-state logic; a rise outside IDLE is deliberately dropped
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        io_jump_d     = io_jump_q;
        press_count_d = press_count_q;
        case (state_q)
            IDLE: begin
                io_jump_d = 1'b0;
                if (rise_s) begin
                    state_d       = HOLD;
                    io_jump_d     = 1'b1;
                    hcnt_d        = HCNT_MAX;
                    press_count_d = press_count_q + 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                io_jump_d = 1'b1;
                if (hcnt_q != HCNT_ZERO) begin
                    hcnt_d = hcnt_q - HCNT_ONE;
                end else begin
                    io_jump_d = 1'b0;
                    if (btn_level_s) begin
                        state_d = WAIT_REL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_REL: begin
                io_jump_d = 1'b0;
                if (!btn_level_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            default: begin
                state_d   = IDLE;
                io_jump_d = 1'b0;
                hcnt_d    = HCNT_ZERO;
            end
        endcase
        busy_d = (state_d == HOLD) || (state_d == WAIT_REL);
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            hcnt_q        <= HCNT_ZERO;
            io_jump_q     <= 1'b0;
            busy_q        <= 1'b0;
            press_count_q <= 8'd0;
            lvl_d_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            io_jump_q     <= io_jump_d;
            busy_q        <= busy_d;
            press_count_q <= press_count_d;
            lvl_d_q       <= btn_level_s;
        end
    end

    assign bus.io_jump     = io_jump_q;
    assign bus.btn_level   = btn_level_s;
    assign bus.press_count = press_count_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_jump_button_conditioner.sv
// Directed bench for jump_button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
module tb_jump_button_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    typedef struct {
        string      tag;
        logic       btn;
        logic       lvl;
        logic       jmp;
        logic       bsy;
        logic [7:0] cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mon_clr = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mon_pulses = 0;
    int   mon_len = 0;
    int   mon_bad = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    jump_button_conditioner_if jif();

    jump_button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CNT_W           (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (jif)
    );

    // Independent pulse counter and width check on io_jump
    always @(negedge clock) begin
        if (mon_clr) begin
            mon_pulses <= 0;
            mon_len    <= 0;
            mon_bad    <= 0;
        end else if (jif.io_jump) begin
            mon_len <= mon_len + 1;
        end else if (mon_len != 0) begin
            mon_pulses <= mon_pulses + 1;
            if (mon_len != HOLD) mon_bad <= mon_bad + 1;
            mon_len <= 0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input string tag, input logic b, input logic l,
                                 input logic j, input logic y, input logic [7:0] c);
        vec_t v;
        v.tag = tag; v.btn = b; v.lvl = l; v.jmp = j; v.bsy = y; v.cnt = c;
        vecs.push_back(v);
    endfunction

    // Clean press held 40 cycles, released for 10
    function automatic void add_clean(input string tag, input logic [7:0] base);
        for (int k = 1; k <= 40; k++)
            push(tag, 1'b1, k >= 6, (k >= 7) && (k <= 14), k >= 7, (k >= 7) ? base + 8'd1 : base);
        for (int k = 41; k <= 50; k++)
            push(tag, 1'b0, k <= 45, 1'b0, k <= 46, base + 8'd1);
    endfunction

    task automatic step(input logic b);
        @(negedge clock);
        jif.btn_raw = b;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] exp_cnt;
        jif.btn_raw = 1'b0;
        reset = 1'b1;

        // Table: glitch, clean, bounce, re-press in HOLD, clean again
        for (int k = 1; k <= 20; k++) push("glitch", k <= 3, 1'b0, 1'b0, 1'b0, 8'd0);
        add_clean("clean1", 8'd0);
        for (int k = 1; k <= 40; k++)
            push("bounce", (k <= 5) ? (k % 2 == 1) : (k <= 30), (k >= 10) && (k <= 35),
                 (k >= 11) && (k <= 18), (k >= 11) && (k <= 36), (k >= 11) ? 8'd2 : 8'd1);
        for (int k = 1; k <= 30; k++)
            push("repress", (k <= 4) || ((k >= 9) && (k <= 20)),
                 ((k >= 6) && (k <= 9)) || ((k >= 14) && (k <= 25)),
                 (k >= 7) && (k <= 14), (k >= 7) && (k <= 26), (k >= 7) ? 8'd3 : 8'd2);
        add_clean("clean2", 8'd3);

        repeat (3) @(posedge clock);
        #1;
        chk("rst io_jump", {15'd0, jif.io_jump}, 16'd0);
        chk("rst btn_level", {15'd0, jif.btn_level}, 16'd0);
        chk("rst busy", {15'd0, jif.busy}, 16'd0);
        chk("rst press_count", {8'd0, jif.press_count}, 16'd0);
        @(negedge clock);
        reset = 1'b0;
        mon_clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].btn);
            chk($sformatf("%s[%0d] btn_level", vecs[i].tag, i), {15'd0, jif.btn_level}, {15'd0, vecs[i].lvl});
            chk($sformatf("%s[%0d] io_jump", vecs[i].tag, i), {15'd0, jif.io_jump}, {15'd0, vecs[i].jmp});
            chk($sformatf("%s[%0d] busy", vecs[i].tag, i), {15'd0, jif.busy}, {15'd0, vecs[i].bsy});
            chk($sformatf("%s[%0d] press_count", vecs[i].tag, i), {8'd0, jif.press_count}, {8'd0, vecs[i].cnt});
        end

        // Reset three cycles into HOLD, button kept held
        for (int k = 1; k <= 9; k++) begin
            step(1'b1);
            if (k == 7) chk("midrst pre io_jump", {15'd0, jif.io_jump}, 16'd1);
        end
        chk("midrst pre count", {8'd0, jif.press_count}, 16'd5);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst io_jump", {15'd0, jif.io_jump}, 16'd0);
        chk("midrst busy", {15'd0, jif.busy}, 16'd0);
        chk("midrst count", {8'd0, jif.press_count}, 16'd0);
        chk("midrst btn_level", {15'd0, jif.btn_level}, 16'd0);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock);
            #1;
            if (k == 6) chk("midrst re6 io_jump", {15'd0, jif.io_jump}, 16'd0);
            if (k == 7) begin
                chk("midrst re7 io_jump", {15'd0, jif.io_jump}, 16'd1);
                chk("midrst re7 count", {8'd0, jif.press_count}, 16'd1);
            end
        end
        for (int k = 0; k < 20; k++) step(1'b0);
        chk("midrst idle busy", {15'd0, jif.busy}, 16'd0);

        // Wrap: 256 presses from a fresh reset
        @(negedge clock);
        reset = 1'b1;
        mon_clr = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mon_clr = 1'b0;
        chk("wrap start count", {8'd0, jif.press_count}, 16'd0);
        for (int p = 1; p <= 256; p++) begin
            for (int k = 0; k < 20; k++) step(1'b1);
            for (int k = 0; k < 12; k++) step(1'b0);
            exp_cnt = p[7:0];
            chk($sformatf("wrap press %0d count", p), {8'd0, jif.press_count}, {8'd0, exp_cnt});
        end
        chk("wrap final count", {8'd0, jif.press_count}, 16'd0);
        chk("wrap pulses", mon_pulses[15:0], 16'd256);
        chk("wrap bad widths", mon_bad[15:0], 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
